// File: rtl/move_pkg.sv
// Shared types and widths for the movement command scheduler.
package move_pkg;

  localparam int unsigned NUM_CMDS = 4;
  localparam int unsigned CNT_W    = 2;
  localparam int unsigned BUDGET_W = 3;
  localparam int unsigned PTR_W    = 2;

  typedef enum logic [1:0] {
    FWD   = 2'd0,
    BWD   = 2'd1,
    ROT_L = 2'd2,
    ROT_R = 2'd3
  } move_cmd_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    OFFER     = 2'd1,
    WAIT_DONE = 2'd2
  } sched_state_t;

  function automatic move_cmd_t onehot_to_cmd(input logic [NUM_CMDS-1:0] oh);
    move_cmd_t c;
    c = FWD;
    if (oh[1]) c = BWD;
    if (oh[2]) c = ROT_L;
    if (oh[3]) c = ROT_R;
    return c;
  endfunction

endpackage

// File: rtl/move_cmd_scheduler_if.sv
// Command handshake between the scheduler and the movement datapath.
interface move_cmd_scheduler_if;

  logic               cmd_valid_out;
  move_pkg::move_cmd_t cmd_out;
  logic               cmd_ready_in;
  logic               cmd_done_in;

  modport master (output cmd_valid_out, output cmd_out, input cmd_ready_in, input cmd_done_in);
  modport slave  (input cmd_valid_out, input cmd_out, output cmd_ready_in, output cmd_done_in);

endinterface

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter: lowest request at or after ptr wins, one-hot grant.
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] grant_c
);

  logic [7:0] rot_dbl;
  logic [3:0] rot_req;
  logic [3:0] rot_gnt;
  logic [7:0] gnt_dbl;

  // Rotate so ptr sits at bit 0, pick the lowest set bit, rotate back.
  always_comb begin
    rot_dbl = {req, req} >> ptr;
    rot_req = rot_dbl[3:0];
    rot_gnt = rot_req & (~rot_req + 4'd1);
    gnt_dbl = {rot_gnt, rot_gnt} << ptr;
    grant_c = gnt_dbl[7:4];
  end

endmodule

// File: rtl/move_cmd_scheduler.sv
// Queues button pulses as saturating per-command counts and issues one move at a time
// under a per-frame budget. Define MOVE_CANCEL_EN to cancel opposing pending pairs.
module move_cmd_scheduler
  import move_pkg::*;
#(
  parameter int unsigned MAX_PENDING    = 3,
  parameter int unsigned CMDS_PER_FRAME = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  fwd_pulse,
  input  logic                  bwd_pulse,
  input  logic                  leftRot_pulse,
  input  logic                  rightRot_pulse,
  input  logic                  frame_start_in,
  move_cmd_scheduler_if.master  cmd_bus,
  output logic                  busy_out,
  output logic                  drop_out,
  output logic [NUM_CMDS-1:0]   pending_out
);

  logic [NUM_CMDS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [BUDGET_W-1:0] budget_q, budget_d;
  logic [PTR_W-1:0]    ptr_q;
  sched_state_t        state_q;

  logic [NUM_CMDS-1:0] pulse_c, nz_c, cancel_c, req_c, grant_c, dec_c, pend_c;
  logic                accept_c, drop_c, start_c;
  move_cmd_t           grant_cmd_c;

  assign pulse_c = {rightRot_pulse, leftRot_pulse, bwd_pulse, fwd_pulse};

  rr_arbiter4 u_arb (
    .req     (req_c),
    .ptr     (ptr_q),
    .grant_c (grant_c)
  );

  // Counter, budget and request bookkeeping for the next cycle.
  always_comb begin
    accept_c = (state_q == OFFER) && cmd_bus.cmd_ready_in;
    dec_c    = accept_c ? (4'b0001 << cmd_bus.cmd_out) : 4'b0000;
    cancel_c = '0;
    drop_c   = 1'b0;
    cnt_d    = cnt_q;
    pend_c   = '0;
    for (int unsigned i = 0; i < NUM_CMDS; i++) nz_c[i] = (cnt_q[i] != '0);
`ifdef MOVE_CANCEL_EN
    if (state_q == IDLE) begin
      cancel_c[1:0] = {2{&nz_c[1:0]}};
      cancel_c[3:2] = {2{&nz_c[3:2]}};
    end
`endif
    req_c = nz_c & ~cancel_c;
    for (int unsigned i = 0; i < NUM_CMDS; i++) begin
      if (cancel_c[i]) begin
        cnt_d[i] = CNT_W'(pulse_c[i]);
      end else if (pulse_c[i] && !dec_c[i]) begin
        if (cnt_q[i] == CNT_W'(MAX_PENDING)) drop_c = 1'b1;
        else                                 cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec_c[i] && !pulse_c[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
      pend_c[i] = (cnt_d[i] != '0);
    end
    budget_d = budget_q;
    if (frame_start_in)
      budget_d = accept_c ? BUDGET_W'(CMDS_PER_FRAME - 1) : BUDGET_W'(CMDS_PER_FRAME);
    else if (accept_c && budget_q != '0)
      budget_d = budget_q - BUDGET_W'(1);
    start_c     = (state_q == IDLE) && (|req_c) && (budget_q != '0);
    grant_cmd_c = onehot_to_cmd(grant_c);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q       <= '0;
      budget_q    <= BUDGET_W'(CMDS_PER_FRAME);
      drop_out    <= 1'b0;
      pending_out <= '0;
    end else begin
      cnt_q       <= cnt_d;
      budget_q    <= budget_d;
      drop_out    <= drop_c;
      pending_out <= pend_c;
    end
  end

  // Issue FSM: one command outstanding from offer until the datapath reports done.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q               <= IDLE;
      cmd_bus.cmd_valid_out <= 1'b0;
      cmd_bus.cmd_out       <= FWD;
      ptr_q                 <= '0;
      busy_out              <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_c) begin
            state_q               <= OFFER;
            cmd_bus.cmd_valid_out <= 1'b1;
            cmd_bus.cmd_out       <= grant_cmd_c;
            busy_out              <= 1'b1;
          end
        end
        OFFER: begin
          if (cmd_bus.cmd_ready_in) begin
            state_q               <= WAIT_DONE;
            cmd_bus.cmd_valid_out <= 1'b0;
            ptr_q                 <= PTR_W'(cmd_bus.cmd_out) + PTR_W'(1);
          end
        end
        WAIT_DONE: begin
          if (cmd_bus.cmd_done_in) begin
            state_q  <= IDLE;
            busy_out <= 1'b0;
          end
        end
        default: begin
          state_q               <= IDLE;
          cmd_bus.cmd_valid_out <= 1'b0;
          busy_out              <= 1'b0;
        end
      endcase
    end
  end

endmodule
